snake_pixel_logic: RTL and testbench

// - Per-pixel colour selector for the snake VGA game; sits between object-hit

---
 rtl/snake_pixel_logic_pkg.sv | 38 +++
 rtl/snake_pixel_logic_if.sv | 24 ++
 rtl/snake_pixel_logic_pixel_priority_mux.sv | 44 ++++
 rtl/snake_pixel_logic.sv | 45 ++++
 tb/tb_snake_pixel_logic.sv | 119 +++++++++++
 5 files changed

// File: rtl/snake_pixel_logic_pkg.sv
// Shared colour definitions for the snake VGA pixel path (RGB332 encoding).
package snake_pkg;

  typedef logic [7:0] rgb332_t;
  typedef logic [2:0] red_t;
  typedef logic [2:0] green_t;
  typedef logic [1:0] blue_t;

  localparam rgb332_t COLOR_SNAKE  = 8'h1C;
  localparam rgb332_t COLOR_APPLE  = 8'hEC;
  localparam rgb332_t COLOR_BORDER = 8'hFF;
  localparam rgb332_t COLOR_LETHAL = 8'hE0;
  localparam rgb332_t COLOR_BG     = 8'h00;
  localparam rgb332_t COLOR_BLANK  = 8'h00;

  // Which flag won the priority resolution for the current pixel.
  typedef enum logic [2:0] {
    SRC_BLANK,
    SRC_LETHAL,
    SRC_SNAKE,
    SRC_APPLE,
    SRC_BORDER,
    SRC_BG
  } pix_src_e;

  function automatic red_t red_of(input rgb332_t c);
    return c[7:5];
  endfunction

  function automatic green_t green_of(input rgb332_t c);
    return c[4:2];
  endfunction

  function automatic blue_t blue_of(input rgb332_t c);
    return c[1:0];
  endfunction

endpackage

// File: rtl/snake_pixel_logic_if.sv
// Pixel flag inputs and RGB332 DAC outputs of the snake pixel logic.
interface snake_pixel_logic_if;
  import snake_pkg::*;

  logic   in_snake;
  logic   in_apple;
  logic   in_border;
  logic   in_lethal;
  logic   in_oobounds;
  red_t   out_VGA_R;
  green_t out_VGA_G;
  blue_t  out_VGA_B;

  modport master (
    output in_snake, in_apple, in_border, in_lethal, in_oobounds,
    input  out_VGA_R, out_VGA_G, out_VGA_B
  );

  modport slave (
    input  in_snake, in_apple, in_border, in_lethal, in_oobounds,
    output out_VGA_R, out_VGA_G, out_VGA_B
  );

endinterface

// File: rtl/snake_pixel_logic_pixel_priority_mux.sv
// Combinational flag-to-colour selector with fixed priority:
// blanking > lethal > snake > apple > border > background.
module pixel_priority_mux
  import snake_pkg::*;
#(
  parameter rgb332_t COLOR_SNAKE_P  = COLOR_SNAKE,
  parameter rgb332_t COLOR_APPLE_P  = COLOR_APPLE,
  parameter rgb332_t COLOR_BORDER_P = COLOR_BORDER,
  parameter rgb332_t COLOR_LETHAL_P = COLOR_LETHAL,
  parameter rgb332_t COLOR_BG_P     = COLOR_BG
) (
  input  logic    in_snake,
  input  logic    in_apple,
  input  logic    in_border,
  input  logic    in_lethal,
  input  logic    in_oobounds,
  output rgb332_t color
);

  pix_src_e src;

  always_comb begin
    src = SRC_BG;
    if (in_oobounds)    src = SRC_BLANK;
    else if (in_lethal) src = SRC_LETHAL;
    else if (in_snake)  src = SRC_SNAKE;
    else if (in_apple)  src = SRC_APPLE;
    else if (in_border) src = SRC_BORDER;
  end

  always_comb begin
    color = COLOR_BG_P;
    unique case (src)
      SRC_BLANK:  color = COLOR_BLANK;
      SRC_LETHAL: color = COLOR_LETHAL_P;
      SRC_SNAKE:  color = COLOR_SNAKE_P;
      SRC_APPLE:  color = COLOR_APPLE_P;
      SRC_BORDER: color = COLOR_BORDER_P;
      SRC_BG:     color = COLOR_BG_P;
      default:    color = COLOR_BG_P;
    endcase
  end

endmodule

// File: rtl/snake_pixel_logic.sv
// Per-pixel colour selector for the snake VGA game; one registered stage
// between the priority mux and the VGA DAC pins.
module snake_pixel_logic
  import snake_pkg::*;
#(
  parameter rgb332_t COLOR_SNAKE_P  = COLOR_SNAKE,
  parameter rgb332_t COLOR_APPLE_P  = COLOR_APPLE,
  parameter rgb332_t COLOR_BORDER_P = COLOR_BORDER,
  parameter rgb332_t COLOR_LETHAL_P = COLOR_LETHAL,
  parameter rgb332_t COLOR_BG_P     = COLOR_BG
) (
  input logic                in_clk,
  input logic                in_reset,
  snake_pixel_logic_if.slave pix
);

  rgb332_t next_color;
  rgb332_t color_q;

  pixel_priority_mux #(
    .COLOR_SNAKE_P  (COLOR_SNAKE_P),
    .COLOR_APPLE_P  (COLOR_APPLE_P),
    .COLOR_BORDER_P (COLOR_BORDER_P),
    .COLOR_LETHAL_P (COLOR_LETHAL_P),
    .COLOR_BG_P     (COLOR_BG_P)
  ) u_mux (
    .in_snake    (pix.in_snake),
    .in_apple    (pix.in_apple),
    .in_border   (pix.in_border),
    .in_lethal   (pix.in_lethal),
    .in_oobounds (pix.in_oobounds),
    .color       (next_color)
  );

  // Reset sits above every flag, so it is applied at the register itself.
  always_ff @(posedge in_clk) begin
    if (in_reset) color_q <= '0;
    else          color_q <= next_color;
  end

  assign pix.out_VGA_R = red_of(color_q);
  assign pix.out_VGA_G = green_of(color_q);
  assign pix.out_VGA_B = blue_of(color_q);

endmodule

// File: tb/tb_snake_pixel_logic.sv
// Scoreboard bench for snake_pixel_logic: directed vectors queue their
// hand-computed colour; a monitor compares the registered output each cycle.
module tb_snake_pixel_logic;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  snake_pixel_logic_if pix ();

  snake_pixel_logic dut (
    .in_clk   (clk),
    .in_reset (rst),
    .pix      (pix.slave)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       snake;
    logic       apple;
    logic       border;
    logic       lethal;
    logic       oob;
    logic [7:0] exp;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic stim_done = 1'b0;

  vec_t vecs[] = '{
    '{"reset_with_snake",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
    '{"reset_hold",         1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
    '{"release_bg",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
    '{"snake_only",         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C},
    '{"apple_only",         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hEC},
    '{"border_only",        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF},
    '{"drop_all",           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
    '{"oob_only",           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00},
    '{"oob_lethal",         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00},
    '{"oob_all_flags",      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00},
    '{"lethal_snake",       1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0},
    '{"lethal_border",      1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hE0},
    '{"lethal_only",        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hE0},
    '{"snake_apple",        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1C},
    '{"apple_border",       1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEC},
    '{"snake_border",       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h1C},
    '{"border_pre_reset",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF},
    '{"reset_mid_border",   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00},
    '{"resume_border",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF},
    '{"reset_all_flags",    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00},
    '{"resume_snake",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1C}
  };

  // Stimulus: drive on the falling edge, queue the colour due after the next rise.
  initial begin
    pix.in_snake    = 1'b0;
    pix.in_apple    = 1'b0;
    pix.in_border   = 1'b0;
    pix.in_lethal   = 1'b0;
    pix.in_oobounds = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      rst             = vecs[i].rst;
      pix.in_snake    = vecs[i].snake;
      pix.in_apple    = vecs[i].apple;
      pix.in_border   = vecs[i].border;
      pix.in_lethal   = vecs[i].lethal;
      pix.in_oobounds = vecs[i].oob;
      sb_q.push_back('{name: vecs[i].name, exp: vecs[i].exp});
    end
    stim_done = 1'b1;
  end

  // Monitor: every cycle carries a valid colour, so pop one entry per edge.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pix.out_VGA_R, pix.out_VGA_G, pix.out_VGA_B};
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got R=%b G=%b B=%b, want R=%b G=%b B=%b",
                   e.name, act[7:5], act[4:2], act[1:0],
                   e.exp[7:5], e.exp[4:2], e.exp[1:0]);
        end
      end
    end
  end

  initial begin
    int cycles = 0;
    while ((!stim_done || sb_q.size() > 0) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 200) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries pending, want 0", sb_q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
